// File: rtl/instr_fetch_stage.sv
// -----------------------------------------------------------------------------
// instr_fetch_stage
//
// Instruction-fetch stage with an IF/ID pipeline register. Holds the PC, issues
// one instruction-memory request at a time, captures the returned word into
// IF/ID and exposes the opcode/funct fields to the decode and control logic.
// Supports a downstream stall (with a one-word hold buffer) and a branch
// redirect that flushes IF/ID and discards any in-flight response.
//
// Parameters
//   PC_WIDTH      : PC / fetch-address width
//   RESET_PC      : PC after reset (word aligned)
//
// Ports
//   clk           : clock, rising edge
//   rst_n         : asynchronous active-low reset
//   imem_req      : one-cycle fetch request strobe (decoded from state)
//   imem_addr     : fetch address, always equal to the PC
//   imem_ready    : one-cycle response strobe
//   imem_rdata    : instruction word, valid with imem_ready
//   stall         : decode cannot accept a new instruction this cycle
//   branch_taken  : redirect pulse (branch & zero)
//   branch_target : redirect address, low two bits ignored
//   id_valid      : IF/ID holds a live instruction
//   id_instr      : IF/ID instruction word
//   id_pc_plus4   : address of the IF/ID instruction + 4
//   instr_op      : id_instr[31:26] to the main control unit
//   instr_funct   : id_instr[5:0] to the ALU control unit
// -----------------------------------------------------------------------------
module instr_fetch_stage #(
    parameter int unsigned          PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ready,
    input  logic [31:0]         imem_rdata,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    output logic                id_valid,
    output logic [31:0]         id_instr,
    output logic [PC_WIDTH-1:0] id_pc_plus4,
    output logic [5:0]          instr_op,
    output logic [5:0]          instr_funct
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t                state_q,       state_d;
    logic [PC_WIDTH-1:0]   pc_q,          pc_d;
    logic                  drop_q,        drop_d;
    logic [31:0]           hold_q,        hold_d;
    logic                  id_valid_q,    id_valid_d;
    logic [31:0]           id_instr_q,    id_instr_d;
    logic [PC_WIDTH-1:0]   id_pc_plus4_q, id_pc_plus4_d;

    logic [PC_WIDTH-1:0]   pc_plus4;
    logic [PC_WIDTH-1:0]   target_aligned;
    logic                  slot_free;
    logic                  unused_tgt_lsbs;

    // Natural wrap of the adder gives the modulo-2^PC_WIDTH increment.
    assign pc_plus4        = pc_q + PC_WIDTH'(4);
    assign target_aligned  = {branch_target[PC_WIDTH-1:2], 2'b00};
    assign unused_tgt_lsbs = ^branch_target[1:0];

    // The IF/ID slot can take a new word if it is empty or is being consumed now.
    assign slot_free = !id_valid_q || !stall;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        drop_d        = drop_q;
        hold_d        = hold_q;
        id_valid_d    = id_valid_q;
        id_instr_d    = id_instr_q;
        id_pc_plus4_d = id_pc_plus4_q;

        // Consumption by decode; a load below in the same cycle overrides it.
        if (id_valid_q && !stall) begin
            id_valid_d = 1'b0;
            id_instr_d = '0;
        end

        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ:  state_d = S_WAIT;
            S_WAIT: begin
                if (imem_ready) begin
                    if (drop_q) begin
                        // Stale response from before a redirect.
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else if (slot_free) begin
                        id_valid_d    = 1'b1;
                        id_instr_d    = imem_rdata;
                        id_pc_plus4_d = pc_plus4;
                        pc_d          = pc_plus4;
                        state_d       = S_REQ;
                    end else begin
                        hold_d  = imem_rdata;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    id_valid_d    = 1'b1;
                    id_instr_d    = hold_q;
                    id_pc_plus4_d = pc_plus4;
                    pc_d          = pc_plus4;
                    state_d       = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Redirect wins over stall, loads and consumption.
        if (branch_taken) begin
            pc_d       = target_aligned;
            id_valid_d = 1'b0;
            id_instr_d = '0;
            hold_d     = '0;
            case (state_q)
                // The request issued this cycle will still answer: drop it.
                S_REQ: begin
                    drop_d  = 1'b1;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_ready) begin
                        // The outstanding response is consumed right here, so
                        // nothing is left in flight; refetch immediately.
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        drop_d  = 1'b1;
                        state_d = S_WAIT;
                    end
                end
                default: begin
                    drop_d  = 1'b0;
                    state_d = S_REQ;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            drop_q        <= 1'b0;
            hold_q        <= '0;
            id_valid_q    <= 1'b0;
            id_instr_q    <= '0;
            id_pc_plus4_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            drop_q        <= drop_d;
            hold_q        <= hold_d;
            id_valid_q    <= id_valid_d;
            id_instr_q    <= id_instr_d;
            id_pc_plus4_q <= id_pc_plus4_d;
        end
    end

    assign imem_req    = (state_q == S_REQ);
    assign imem_addr   = pc_q;
    assign id_valid    = id_valid_q;
    assign id_instr    = id_instr_q;
    assign id_pc_plus4 = id_pc_plus4_q;
    assign instr_op    = id_instr_q[31:26];
    assign instr_funct = id_instr_q[5:0];

endmodule

// File: tb/tb_instr_fetch_stage.sv
module tb_instr_fetch_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (RESET_PC = 0)
    logic        rst_n, imem_ready, stall, branch_taken;
    logic [31:0] imem_rdata, branch_target;
    logic        imem_req, id_valid;
    logic [31:0] imem_addr, id_instr, id_pc_plus4;
    logic [5:0]  instr_op, instr_funct;

    // Wrap instance (RESET_PC = 0xFFFFFFFC)
    logic        rst2_n, ready2, stall2, branch2;
    logic [31:0] rdata2, target2;
    logic        req2, valid2;
    logic [31:0] addr2, instr2, pc4_2;
    logic [5:0]  op2, funct2;

    instr_fetch_stage #(.PC_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc_plus4(id_pc_plus4),
        .instr_op(instr_op), .instr_funct(instr_funct)
    );

    instr_fetch_stage #(.PC_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst_n(rst2_n),
        .imem_req(req2), .imem_addr(addr2),
        .imem_ready(ready2), .imem_rdata(rdata2),
        .stall(stall2), .branch_taken(branch2), .branch_target(target2),
        .id_valid(valid2), .id_instr(instr2), .id_pc_plus4(pc4_2),
        .instr_op(op2), .instr_funct(funct2)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic [5:0]  op;
        logic [5:0]  funct;
    } id_exp_t;

    logic [31:0] exp_addr[$];
    id_exp_t     exp_id[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push_id(input logic [31:0] instr, input logic [31:0] pc4,
                           input logic [5:0] op, input logic [5:0] funct);
        id_exp_t e;
        e = '{instr, pc4, op, funct};
        exp_id.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) until the chosen instance raises imem_req.
    task automatic wait_req(input int which);
        for (int i = 0; i < 20; i++) begin
            if ((which == 0 && imem_req) || (which == 1 && req2)) return;
            tick();
        end
        checks++;
        errors++;
        $display("FAIL wait_req%0d actual=timeout required=imem_req", which);
    endtask

    // Scoreboard monitor: every request must match the next expected address,
    // every instruction taken by decode must match the next expected entry.
    always @(negedge clk) begin
        if (rst_n) begin
            if (imem_req) begin
                if (exp_addr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL req_unexpected actual=%h required=none", imem_addr);
                end else begin
                    chk("req_addr", imem_addr, exp_addr.pop_front());
                end
            end
            if (id_valid && !stall) begin
                if (exp_id.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL id_unexpected actual=%h required=none", id_instr);
                end else begin
                    id_exp_t e;
                    e = exp_id.pop_front();
                    chk("id_instr", id_instr, e.instr);
                    chk("id_pc_plus4", id_pc_plus4, e.pc4);
                    chk("instr_op", {26'd0, instr_op}, {26'd0, e.op});
                    chk("instr_funct", {26'd0, instr_funct}, {26'd0, e.funct});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; imem_ready = 1'b0; imem_rdata = '0; stall = 1'b0;
        branch_taken = 1'b0; branch_target = '0;
        rst2_n = 1'b0; ready2 = 1'b0; rdata2 = '0; stall2 = 1'b0;
        branch2 = 1'b0; target2 = '0;

        // ---------------- reset state
        repeat (3) tick();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_instr", id_instr, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_pc4", id_pc_plus4, 32'd0);
        chk("rst_opfn", {20'd0, instr_op, instr_funct}, 32'd0);

        exp_addr.push_back(32'h0);
        rst_n = 1'b1;
        chk("idle_req", {31'd0, imem_req}, 32'd0);
        wait_req(0);

        // ---------------- R-type loaded while stall is already raised
        push_id(32'h0085_1020, 32'h4, 6'b000000, 6'b100000);
        exp_addr.push_back(32'h4);
        tick();
        imem_ready = 1'b1; imem_rdata = 32'h0085_1020; stall = 1'b1;
        tick();
        imem_ready = 1'b0;
        chk("rt_valid", {31'd0, id_valid}, 32'd1);

        // ---------------- response while slot busy -> HOLD
        tick();
        imem_ready = 1'b1; imem_rdata = 32'h8C88_0004;
        tick();
        imem_ready = 1'b0;
        chk("hold_instr", id_instr, 32'h0085_1020);
        chk("hold_valid", {31'd0, id_valid}, 32'd1);
        chk("hold_req", {31'd0, imem_req}, 32'd0);
        tick();
        chk("hold_req2", {31'd0, imem_req}, 32'd0);
        chk("hold_instr2", id_instr, 32'h0085_1020);

        push_id(32'h8C88_0004, 32'h8, 6'b100011, 6'b000100);
        exp_addr.push_back(32'h8);
        stall = 1'b0;
        tick();
        chk("lw_instr", id_instr, 32'h8C88_0004);

        // ---------------- branch in WAIT, pending response dropped
        tick();
        branch_taken = 1'b1; branch_target = 32'h43;
        tick();
        branch_taken = 1'b0;
        chk("br_valid", {31'd0, id_valid}, 32'd0);
        chk("br_instr", id_instr, 32'd0);
        chk("br_req", {31'd0, imem_req}, 32'd0);
        exp_addr.push_back(32'h40);
        imem_ready = 1'b1; imem_rdata = 32'h1000_0005;
        tick();
        imem_ready = 1'b0;
        chk("drop_valid", {31'd0, id_valid}, 32'd0);
        chk("drop_instr", id_instr, 32'd0);

        // ---------------- branch + stall + ready: flush wins
        exp_addr.push_back(32'h44);
        tick();
        imem_ready = 1'b1; imem_rdata = 32'h2009_0007; stall = 1'b1;
        tick();
        imem_ready = 1'b0;
        chk("addi_valid", {31'd0, id_valid}, 32'd1);
        tick();
        imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        branch_taken = 1'b1; branch_target = 32'h100;
        exp_addr.push_back(32'h100);
        tick();
        imem_ready = 1'b0; branch_taken = 1'b0; stall = 1'b0;
        chk("flush_valid", {31'd0, id_valid}, 32'd0);
        chk("flush_instr", id_instr, 32'd0);

        // Next fetch at the target must load normally (no leftover drop).
        push_id(32'h03E0_0008, 32'h104, 6'b000000, 6'b001000);
        exp_addr.push_back(32'h104);
        tick();
        imem_ready = 1'b1; imem_rdata = 32'h03E0_0008;
        tick();
        imem_ready = 1'b0;
        repeat (3) tick();
        chk("sb_addr_left", exp_addr.size(), 32'd0);
        chk("sb_id_left", exp_id.size(), 32'd0);

        // ---------------- wrap instance
        chk("w_rst_addr", addr2, 32'hFFFF_FFFC);
        chk("w_rst_req", {31'd0, req2}, 32'd0);
        rst2_n = 1'b1;
        wait_req(1);
        chk("w_req_addr", addr2, 32'hFFFF_FFFC);
        tick();
        ready2 = 1'b1; rdata2 = 32'h0085_1020; stall2 = 1'b1;
        tick();
        ready2 = 1'b0;
        chk("w_valid", {31'd0, valid2}, 32'd1);
        chk("w_pc4", pc4_2, 32'h0);
        chk("w_next_addr", addr2, 32'h0);
        chk("w_next_req", {31'd0, req2}, 32'd1);
        tick();

        // Reset asserted mid-WAIT takes effect without a clock edge.
        rst2_n = 1'b0;
        #1;
        chk("w_mid_req", {31'd0, req2}, 32'd0);
        chk("w_mid_valid", {31'd0, valid2}, 32'd0);
        chk("w_mid_instr", instr2, 32'd0);
        chk("w_mid_addr", addr2, 32'hFFFF_FFFC);
        chk("w_mid_pc4", pc4_2, 32'd0);
        chk("w_mid_opfn", {20'd0, op2, funct2}, 32'd0);

        // Late responses in IDLE and REQ are ignored.
        tick();
        rst2_n = 1'b1; ready2 = 1'b1; rdata2 = 32'h8C88_0004;
        tick();
        tick();
        ready2 = 1'b0;
        chk("w_late_valid", {31'd0, valid2}, 32'd0);
        chk("w_late_instr", instr2, 32'd0);
        tick();
        chk("w_late_valid2", {31'd0, valid2}, 32'd0);
        chk("w_late_addr", addr2, 32'hFFFF_FFFC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
